// File: rtl/stim_mon_pkg.sv
// Shared types and defaults for the H-bridge pulse monitor.
package stim_mon_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int GAP_MAX_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PH_A = 2'd1,
    ST_GAP  = 2'd2,
    ST_PH_C = 2'd3
  } mon_state_e;

  typedef enum logic [2:0] {
    CODE_Z   = 3'd0,
    CODE_A   = 3'd1,
    CODE_C   = 3'd2,
    CODE_S   = 3'd3,
    CODE_ILL = 3'd4
  } drive_code_e;

  // Shoot-through has priority; Z ignores the current-source enable.
  function automatic drive_code_e classify(input logic ena, input logic ano_top,
                                           input logic ano_bot, input logic cat_top,
                                           input logic cat_bot);
    drive_code_e c;
    if ((ano_top & ano_bot) | (cat_top & cat_bot)) begin
      c = CODE_S;
    end else if (!(ano_top | ano_bot | cat_top | cat_bot)) begin
      c = CODE_Z;
    end else if (ena & ano_top & cat_bot & !ano_bot & !cat_top) begin
      c = CODE_A;
    end else if (ena & cat_top & ano_bot & !ano_top & !cat_bot) begin
      c = CODE_C;
    end else begin
      c = CODE_ILL;
    end
    return c;
  endfunction

endpackage

// File: rtl/stim_phase_decode.sv
// Input register for the drive lines plus combinational pattern decode.
module stim_phase_decode
  import stim_mon_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ano_top,
  input  logic        i_ano_bot,
  input  logic        i_cat_top,
  input  logic        i_cat_bot,
  input  logic        i_curr_ena,
  output drive_code_e o_code,
  output logic        o_code_vld
);

  logic [4:0] pins_q, pins_d;
  logic       vld_q, vld_d;

  // Sample the pins every cycle; valid marks the first real sample after reset.
  always_comb begin
    pins_d = {i_curr_ena, i_ano_top, i_ano_bot, i_cat_top, i_cat_bot};
    vld_d  = 1'b1;
  end

  // Input register stage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pins_q <= 5'b00000;
      vld_q  <= 1'b0;
    end else begin
      pins_q <= pins_d;
      vld_q  <= vld_d;
    end
  end

  // Decode the registered sample.
  always_comb begin
    o_code     = classify(pins_q[4], pins_q[3], pins_q[2], pins_q[1], pins_q[0]);
    o_code_vld = vld_q;
  end

endmodule

// File: rtl/stim_pulse_monitor.sv
// Biphasic pulse monitor: phase FSM, width counters, report registers and sticky faults.
module stim_pulse_monitor
  import stim_mon_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int GAP_MAX = GAP_MAX_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ano_top,
  input  logic             i_ano_bot,
  input  logic             i_cat_top,
  input  logic             i_cat_bot,
  input  logic             i_curr_ena,
  input  logic             i_clr_err,
  output logic             o_pulse_vld,
  output logic [CNT_W-1:0] o_ano_width,
  output logic [CNT_W-1:0] o_gap_width,
  output logic [CNT_W-1:0] o_cat_width,
  output logic [CNT_W-1:0] o_idle_width,
  output logic [CNT_W-1:0] o_pulse_cnt,
  output logic             o_imbal,
  output logic             o_err_shoot,
  output logic             o_err_seq,
  output logic             o_err_tmo
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  drive_code_e      code;
  logic             code_vld;
  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d, idle_lat_q, idle_lat_d;
  logic [CNT_W-1:0] ano_cnt_q, ano_cnt_d, gap_cnt_q, gap_cnt_d, cat_cnt_q, cat_cnt_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d, gap_inc;
  logic [CNT_W-1:0] ano_w_q, ano_w_d, gap_w_q, gap_w_d, cat_w_q, cat_w_d, idle_w_q, idle_w_d;
  logic             vld_q, vld_d, imbal_q, imbal_d;
  logic             shoot_q, shoot_d, seq_q, seq_d, tmo_q, tmo_d;
  logic             shoot_hit, seq_hit, tmo_hit, report;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == '1) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  stim_phase_decode u_decode (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_ano_top  (i_ano_top),
    .i_ano_bot  (i_ano_bot),
    .i_cat_top  (i_cat_top),
    .i_cat_bot  (i_cat_bot),
    .i_curr_ena (i_curr_ena),
    .o_code     (code),
    .o_code_vld (code_vld)
  );

  // Phase tracking, counter updates, report and fault flag next-state.
  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    idle_lat_d  = idle_lat_q;
    ano_cnt_d   = ano_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    cat_cnt_d   = cat_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    ano_w_d     = ano_w_q;
    gap_w_d     = gap_w_q;
    cat_w_d     = cat_w_q;
    idle_w_d    = idle_w_q;
    imbal_d     = imbal_q;
    vld_d       = 1'b0;
    shoot_hit   = 1'b0;
    seq_hit     = 1'b0;
    tmo_hit     = 1'b0;
    report      = 1'b0;
    gap_inc     = sat_inc(gap_cnt_q);

    if (!code_vld) begin
      state_d = state_q;
    end else if (code == CODE_S) begin
      shoot_hit  = 1'b1;
      state_d    = ST_IDLE;
      idle_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          case (code)
            CODE_Z: idle_cnt_d = sat_inc(idle_cnt_q);
            CODE_A: begin
              idle_lat_d = idle_cnt_q;
              ano_cnt_d  = CNT_ONE;
              gap_cnt_d  = '0;
              cat_cnt_d  = '0;
              state_d    = ST_PH_A;
            end
            default: begin
              seq_hit    = 1'b1;
              idle_cnt_d = '0;
            end
          endcase
        end
        ST_PH_A: begin
          case (code)
            CODE_A: ano_cnt_d = sat_inc(ano_cnt_q);
            CODE_Z: begin
              gap_cnt_d = CNT_ONE;
              if (GAP_MAX <= 1) begin
                tmo_hit    = 1'b1;
                state_d    = ST_IDLE;
                idle_cnt_d = '0;
              end else begin
                state_d = ST_GAP;
              end
            end
            CODE_C: begin
              gap_cnt_d = '0;
              cat_cnt_d = CNT_ONE;
              state_d   = ST_PH_C;
            end
            default: begin
              seq_hit    = 1'b1;
              state_d    = ST_IDLE;
              idle_cnt_d = '0;
            end
          endcase
        end
        ST_GAP: begin
          case (code)
            CODE_Z: begin
              gap_cnt_d = gap_inc;
              if (32'(gap_inc) >= 32'(GAP_MAX)) begin
                tmo_hit    = 1'b1;
                state_d    = ST_IDLE;
                idle_cnt_d = '0;
              end else begin
                state_d = ST_GAP;
              end
            end
            CODE_C: begin
              cat_cnt_d = CNT_ONE;
              state_d   = ST_PH_C;
            end
            default: begin
              seq_hit    = 1'b1;
              state_d    = ST_IDLE;
              idle_cnt_d = '0;
            end
          endcase
        end
        ST_PH_C: begin
          case (code)
            CODE_C: cat_cnt_d = sat_inc(cat_cnt_q);
            CODE_Z: begin
              report     = 1'b1;
              idle_cnt_d = CNT_ONE;
              state_d    = ST_IDLE;
            end
            default: begin
              seq_hit    = 1'b1;
              state_d    = ST_IDLE;
              idle_cnt_d = '0;
            end
          endcase
        end
        default: begin
          state_d    = ST_IDLE;
          idle_cnt_d = '0;
        end
      endcase
    end

    if (report) begin
      ano_w_d     = ano_cnt_q;
      gap_w_d     = gap_cnt_q;
      cat_w_d     = cat_cnt_q;
      idle_w_d    = idle_lat_q;
      imbal_d     = (ano_cnt_q != cat_cnt_q);
      pulse_cnt_d = sat_inc(pulse_cnt_q);
      vld_d       = 1'b1;
    end else begin
      vld_d = 1'b0;
    end

    // A fault in the clearing cycle wins over the clear.
    shoot_d = (shoot_q & ~i_clr_err) | shoot_hit;
    seq_d   = (seq_q & ~i_clr_err) | seq_hit;
    tmo_d   = (tmo_q & ~i_clr_err) | tmo_hit;
  end

  // State, counter and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      idle_cnt_q  <= '0;
      idle_lat_q  <= '0;
      ano_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      cat_cnt_q   <= '0;
      pulse_cnt_q <= '0;
      ano_w_q     <= '0;
      gap_w_q     <= '0;
      cat_w_q     <= '0;
      idle_w_q    <= '0;
      imbal_q     <= 1'b0;
      vld_q       <= 1'b0;
      shoot_q     <= 1'b0;
      seq_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      idle_lat_q  <= idle_lat_d;
      ano_cnt_q   <= ano_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      cat_cnt_q   <= cat_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      ano_w_q     <= ano_w_d;
      gap_w_q     <= gap_w_d;
      cat_w_q     <= cat_w_d;
      idle_w_q    <= idle_w_d;
      imbal_q     <= imbal_d;
      vld_q       <= vld_d;
      shoot_q     <= shoot_d;
      seq_q       <= seq_d;
      tmo_q       <= tmo_d;
    end
  end

  assign o_pulse_vld  = vld_q;
  assign o_ano_width  = ano_w_q;
  assign o_gap_width  = gap_w_q;
  assign o_cat_width  = cat_w_q;
  assign o_idle_width = idle_w_q;
  assign o_pulse_cnt  = pulse_cnt_q;
  assign o_imbal      = imbal_q;
  assign o_err_shoot  = shoot_q;
  assign o_err_seq    = seq_q;
  assign o_err_tmo    = tmo_q;

endmodule

// File: tb/tb_stim_pulse_monitor.sv
// Bench for stim_pulse_monitor: two parameterisations share stimulus and are
// checked each cycle against a run-length model of the pin history.
module tb_stim_pulse_monitor;

  localparam int K_Z = 0, K_A = 1, K_C = 2, K_S = 3, K_ILL = 4;
  localparam int L_NONE = 0, L_I = 1, L_A = 2, L_G = 3, L_C = 4;
  localparam logic [4:0] P_Z = 5'b00000, P_ZE = 5'b10000, P_A = 5'b11001, P_C = 5'b10110;
  localparam logic [4:0] P_S = 5'b11100, P_ILL = 5'b01001;

  typedef struct {
    int vld, ano, gap, cat, idle, cnt, imbal, shoot, seq, tmo;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, clr = 1'b0;
  logic p_ena = 1'b0, p_at = 1'b0, p_ab = 1'b0, p_ct = 1'b0, p_cb = 1'b0;

  logic        o0_vld, o0_imbal, o0_shoot, o0_seq, o0_tmo;
  logic [15:0] o0_ano, o0_gap, o0_cat, o0_idle, o0_cnt;
  logic        o1_vld, o1_imbal, o1_shoot, o1_seq, o1_tmo;
  logic [3:0]  o1_ano, o1_gap, o1_cat, o1_idle, o1_cnt;

  stim_pulse_monitor #(.CNT_W(16), .GAP_MAX(255)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_ano_top(p_at), .i_ano_bot(p_ab), .i_cat_top(p_ct),
    .i_cat_bot(p_cb), .i_curr_ena(p_ena), .i_clr_err(clr), .o_pulse_vld(o0_vld),
    .o_ano_width(o0_ano), .o_gap_width(o0_gap), .o_cat_width(o0_cat),
    .o_idle_width(o0_idle), .o_pulse_cnt(o0_cnt), .o_imbal(o0_imbal),
    .o_err_shoot(o0_shoot), .o_err_seq(o0_seq), .o_err_tmo(o0_tmo));

  stim_pulse_monitor #(.CNT_W(4), .GAP_MAX(4)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_ano_top(p_at), .i_ano_bot(p_ab), .i_cat_top(p_ct),
    .i_cat_bot(p_cb), .i_curr_ena(p_ena), .i_clr_err(clr), .o_pulse_vld(o1_vld),
    .o_ano_width(o1_ano), .o_gap_width(o1_gap), .o_cat_width(o1_cat),
    .o_idle_width(o1_idle), .o_pulse_cnt(o1_cnt), .o_imbal(o1_imbal),
    .o_err_shoot(o1_shoot), .o_err_seq(o1_seq), .o_err_tmo(o1_tmo));

  int   n_checks = 0, n_fail = 0;
  exp_t cur[2], prev[2];
  int   r_idle[2], r_ano[2], r_gap[2], r_cat[2], last[2];
  int   cmax[2], gmax[2];
  bit   clr_dly = 1'b0;

  function automatic int code_of(input logic [4:0] p);
    logic e, at, ab, ct, cb;
    {e, at, ab, ct, cb} = p;
    if ((at && ab) || (ct && cb)) return K_S;
    if (!at && !ab && !ct && !cb) return K_Z;
    if (e && at && cb && !ab && !ct) return K_A;
    if (e && ct && ab && !at && !cb) return K_C;
    return K_ILL;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input int exp_v);
    n_checks++;
    assert (obs === 16'(exp_v)) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic wipe(input int m);
    r_idle[m] = 0; r_ano[m] = 0; r_gap[m] = 0; r_cat[m] = 0; last[m] = L_NONE;
  endtask

  // Apply one pin-cycle to the run-length history of model m.
  task automatic model_step(input int m, input int k, input bit c);
    exp_t e;
    e = cur[m];
    e.vld = 0;
    if (c) begin e.shoot = 0; e.seq = 0; e.tmo = 0; end
    if (k == K_S) begin
      e.shoot = 1; wipe(m);
    end else if (k == K_ILL) begin
      e.seq = 1; wipe(m);
    end else if (k == K_Z) begin
      if (last[m] == L_C) begin
        e.ano = sat(r_ano[m], cmax[m]); e.gap = sat(r_gap[m], cmax[m]);
        e.cat = sat(r_cat[m], cmax[m]); e.idle = sat(r_idle[m], cmax[m]);
        e.imbal = (e.ano != e.cat) ? 1 : 0;
        e.cnt = sat(e.cnt + 1, cmax[m]);
        e.vld = 1;
        wipe(m); r_idle[m] = 1; last[m] = L_I;
      end else if (last[m] == L_A || last[m] == L_G) begin
        r_gap[m]++; last[m] = L_G;
        if (r_gap[m] >= gmax[m]) begin e.tmo = 1; wipe(m); end
      end else begin
        r_idle[m]++; last[m] = L_I;
      end
    end else if (k == K_A) begin
      if (last[m] == L_NONE || last[m] == L_I) begin
        r_ano[m] = 1; r_gap[m] = 0; r_cat[m] = 0; last[m] = L_A;
      end else if (last[m] == L_A) begin
        r_ano[m]++;
      end else begin
        e.seq = 1; wipe(m);
      end
    end else begin
      if (last[m] == L_A || last[m] == L_G) begin
        r_cat[m] = 1; last[m] = L_C;
      end else if (last[m] == L_C) begin
        r_cat[m]++;
      end else begin
        e.seq = 1; wipe(m);
      end
    end
    cur[m] = e;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".d0.vld"},   16'(o0_vld),   prev[0].vld);
    chk({tag, ".d0.ano"},   o0_ano,        prev[0].ano);
    chk({tag, ".d0.gap"},   o0_gap,        prev[0].gap);
    chk({tag, ".d0.cat"},   o0_cat,        prev[0].cat);
    chk({tag, ".d0.idle"},  o0_idle,       prev[0].idle);
    chk({tag, ".d0.cnt"},   o0_cnt,        prev[0].cnt);
    chk({tag, ".d0.imbal"}, 16'(o0_imbal), prev[0].imbal);
    chk({tag, ".d0.shoot"}, 16'(o0_shoot), prev[0].shoot);
    chk({tag, ".d0.seq"},   16'(o0_seq),   prev[0].seq);
    chk({tag, ".d0.tmo"},   16'(o0_tmo),   prev[0].tmo);
    chk({tag, ".d1.vld"},   16'(o1_vld),   prev[1].vld);
    chk({tag, ".d1.ano"},   16'(o1_ano),   prev[1].ano);
    chk({tag, ".d1.gap"},   16'(o1_gap),   prev[1].gap);
    chk({tag, ".d1.cat"},   16'(o1_cat),   prev[1].cat);
    chk({tag, ".d1.idle"},  16'(o1_idle),  prev[1].idle);
    chk({tag, ".d1.cnt"},   16'(o1_cnt),   prev[1].cnt);
    chk({tag, ".d1.imbal"}, 16'(o1_imbal), prev[1].imbal);
    chk({tag, ".d1.shoot"}, 16'(o1_shoot), prev[1].shoot);
    chk({tag, ".d1.seq"},   16'(o1_seq),   prev[1].seq);
    chk({tag, ".d1.tmo"},   16'(o1_tmo),   prev[1].tmo);
  endtask

  // One pin cycle; the clear request travels with it and reaches the DUT one cycle later,
  // landing on the same edge that acts on this pin sample.
  task automatic step(input logic [4:0] p, input bit c);
    int k;
    @(negedge clk);
    rst = 1'b0;
    {p_ena, p_at, p_ab, p_ct, p_cb} = p;
    clr = clr_dly;
    clr_dly = c;
    k = code_of(p);
    model_step(0, k, c);
    model_step(1, k, c);
    @(posedge clk);
    #1;
    check_all("cyc");
    prev[0] = cur[0];
    prev[1] = cur[1];
  endtask

  task automatic run(input logic [4:0] p, input int n);
    for (int i = 0; i < n; i++) step(p, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    {p_ena, p_at, p_ab, p_ct, p_cb} = 5'b00000;
    clr = 1'b0;
    clr_dly = 1'b0;
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      cur[m] = '{default: 0};
      prev[m] = cur[m];
      wipe(m);
    end
    check_all("rst");
  endtask

  initial begin
    logic [4:0] ill_tab [4];
    logic [4:0] s_tab [3];
    int r;
    ill_tab = '{5'b01001, 5'b10010, 5'b00110, 5'b11000};
    s_tab   = '{5'b11100, 5'b10011, 5'b01111};
    cmax = '{65535, 15};
    gmax = '{255, 4};

    do_reset();
    do_reset();
    chk("rst_cnt", o0_cnt, 0);
    chk("rst_vld", 16'(o0_vld), 0);

    // Nominal pulse.
    run(P_Z, 10); run(P_A, 7); run(P_Z, 2); run(P_C, 7);
    step(P_Z, 1'b0); step(P_Z, 1'b0);
    chk("nom_vld", 16'(o0_vld), 1);
    chk("nom_ano", o0_ano, 7);
    chk("nom_gap", o0_gap, 2);
    chk("nom_cat", o0_cat, 7);
    chk("nom_idle", o0_idle, 10);
    chk("nom_cnt", o0_cnt, 1);
    chk("nom_imbal", 16'(o0_imbal), 0);
    chk("nom_errs", 16'({o0_shoot, o0_seq, o0_tmo}), 0);
    step(P_Z, 1'b0);
    chk("nom_vld_one", 16'(o0_vld), 0);

    // No inter-phase gap.
    run(P_A, 5); run(P_C, 3); run(P_ZE, 3);
    chk("nogap_ano", o0_ano, 5);
    chk("nogap_gap", o0_gap, 0);
    chk("nogap_cat", o0_cat, 3);
    chk("nogap_imbal", 16'(o0_imbal), 1);

    // Shoot-through mid anodic phase, then a clean pulse.
    run(P_Z, 2); run(P_A, 3); step(P_S, 1'b0); run(P_Z, 4);
    run(P_A, 4); run(P_Z, 1); run(P_C, 4); run(P_Z, 3);
    chk("shoot_flag", 16'(o0_shoot), 1);
    chk("shoot_cnt", o0_cnt, 3);
    chk("shoot_idle", o0_idle, 4);
    step(P_Z, 1'b1); run(P_Z, 2);
    chk("clr_shoot", 16'(o0_shoot), 0);

    // Gap timeout on the GAP_MAX=4 instance, then a late cathodic phase.
    run(P_Z, 3); run(P_A, 2); run(P_Z, 4); run(P_Z, 2);
    chk("tmo_d1", 16'(o1_tmo), 1);
    chk("tmo_d0", 16'(o0_tmo), 0);
    step(P_C, 1'b0); run(P_Z, 3);
    chk("tmo_seq_d1", 16'(o1_seq), 1);
    chk("late_gap_d0", o0_gap, 6);
    step(P_Z, 1'b1); run(P_Z, 2);
    run(P_A, 1); run(P_Z, 256); step(P_C, 1'b0); run(P_Z, 2);
    chk("tmo_d0_long", 16'(o0_tmo), 1);

    // Cathodic first, and the clear/new-error race.
    step(P_Z, 1'b1); run(P_Z, 3);
    step(P_C, 1'b0); run(P_Z, 2);
    chk("cfirst_seq", 16'(o0_seq), 1);
    step(P_C, 1'b1); run(P_Z, 2);
    chk("race_seq", 16'(o0_seq), 1);
    step(P_Z, 1'b1); run(P_Z, 2);
    chk("clr_seq", 16'(o0_seq), 0);

    // Saturation on the 4-bit instance.
    run(P_Z, 3); run(P_A, 20); run(P_C, 1); run(P_Z, 3);
    chk("sat_ano_d1", 16'(o1_ano), 15);
    chk("sat_ano_d0", o0_ano, 20);
    chk("sat_imbal_d1", 16'(o1_imbal), 1);

    // Reset in the middle of the cathodic phase.
    run(P_Z, 2); run(P_A, 3); run(P_C, 2);
    do_reset();
    run(P_Z, 3);
    chk("mid_rst_cnt", o0_cnt, 0);
    chk("mid_rst_vld", 16'(o0_vld), 0);

    // Randomised pulse trains with occasional faults and clears.
    for (int it = 0; it < 160; it++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        step(s_tab[$urandom_range(0, 2)], 1'b0);
      end else if (r == 1) begin
        step(ill_tab[$urandom_range(0, 3)], 1'b0);
      end else if (r == 2) begin
        step(($urandom_range(0, 1) != 0) ? P_Z : P_ZE, 1'b1);
      end else begin
        for (int i = $urandom_range(0, 4); i > 0; i--) step(($urandom_range(0, 1) != 0) ? P_Z : P_ZE, 1'b0);
        run(P_A, $urandom_range(1, 6));
        run(P_Z, $urandom_range(0, 5));
        run(P_C, $urandom_range(1, 6));
      end
    end
    run(P_Z, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
